sync_scheduler: RTL

- Sequences each pixel transaction through the capture datapath:
  - pops one entry from the ColorTransform show-ahead FIFO;
  - issues its (x,y) to the Homography unit;
  - waits for the Homography result and paces the next pop.
- Guarantees only one pixel is in flight, so the single-entry buffer in the sync/compare stage is never overwritten before its matching Homography result arrives.
- Tracks raster position and frame boundaries, and flags protocol and ordering errors.

---
 rtl/sync_sched_pkg.sv | 25 ++
 rtl/sync_scheduler_if.sv | 24 ++
 rtl/pix_raster_counter.sv | 40 ++++
 rtl/sync_scheduler.sv | 130 +++++++++++++
 4 files changed

// File: rtl/sync_sched_pkg.sv
// rtl/sync_sched_pkg.sv - shared types and constants for the pixel transaction scheduler
package sync_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_POP   = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } sched_state_t;

    localparam int PIX_W   = 44;
    localparam int COORD_W = 10;

    // fifo_q layout: {x, y, r, g, b}
    localparam int X_MSB = 43;
    localparam int X_LSB = 34;
    localparam int Y_MSB = 33;
    localparam int Y_LSB = 24;

    localparam int H_ACTIVE_DEF       = 640;
    localparam int V_ACTIVE_DEF       = 480;
    localparam int TIMEOUT_CYCLES_DEF = 1023;

endpackage

// File: rtl/sync_scheduler_if.sv
// rtl/sync_scheduler_if.sv - FIFO and Homography handshake bundle seen by the scheduler
interface sync_scheduler_if;
    import sync_sched_pkg::*;

    logic               fifo_empty;
    logic [PIX_W-1:0]   fifo_q;
    logic               rdreq;
    logic               hom_req;
    logic [COORD_W-1:0] hom_x;
    logic [COORD_W-1:0] hom_y;
    logic               hom_busy;
    logic               hom_ready;

    modport master (
        input  fifo_empty, fifo_q, hom_busy, hom_ready,
        output rdreq, hom_req, hom_x, hom_y
    );

    modport slave (
        output fifo_empty, fifo_q, hom_busy, hom_ready,
        input  rdreq, hom_req, hom_x, hom_y
    );

endinterface

// File: rtl/pix_raster_counter.sv
// rtl/pix_raster_counter.sv - expected raster position with line/frame wrap and frame_done pulse
module pix_raster_counter
    import sync_sched_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic               clk_25,
    input  logic               rst_n,
    input  logic               advance,
    output logic [COORD_W-1:0] col,
    output logic [COORD_W-1:0] row,
    output logic               frame_done
);

    logic last_col;
    logic last_row;

    assign last_col = (col == COORD_W'(H_ACTIVE - 1));
    assign last_row = (row == COORD_W'(V_ACTIVE - 1));

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            col        <= '0;
            row        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= advance && last_col && last_row;
            if (advance) begin
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sync_scheduler.sv
// rtl/sync_scheduler.sv - one-pixel-in-flight sequencer from FIFO pop to Homography result
// Optional watchdog in WAIT enabled by SYNC_SCHED_TIMEOUT_EN.
module sync_scheduler
    import sync_sched_pkg::*;
#(
    parameter int H_ACTIVE       = H_ACTIVE_DEF,
    parameter int V_ACTIVE       = V_ACTIVE_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic               clk_25,
    input  logic               rst_n,
    input  logic               enable,
    sync_scheduler_if.master   bus,
    output logic               busy,
    output logic [COORD_W-1:0] col,
    output logic [COORD_W-1:0] row,
    output logic               frame_done,
    output logic               order_err,
    output logic               proto_err,
    output logic               timeout_err
);

    sched_state_t state;
    sched_state_t state_next;

    logic         timeout_hit;
    logic         rdreq_d;
    logic         hom_req_d;
    logic         busy_d;
    logic         order_err_d;
    logic         proto_err_d;
    logic [23:0]  rgb_unused;

    assign rgb_unused = bus.fifo_q[Y_LSB-1:0];

`ifdef SYNC_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;

    // wd_cnt holds the number of WAIT cycles already spent before this one
    assign timeout_hit = (state == ST_WAIT) && !bus.hom_ready &&
                         (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == ST_WAIT && state_next == ST_WAIT) begin
                wd_cnt <= wd_cnt + 1'b1;
            end else begin
                wd_cnt <= '0;
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    localparam int timeout_unused = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (enable && !bus.fifo_empty) state_next = ST_POP;
            ST_POP:   state_next = ST_ISSUE;
            ST_ISSUE: if (!bus.hom_busy) state_next = ST_WAIT;
            ST_WAIT:  if (bus.hom_ready || timeout_hit) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with the state
    always_comb begin
        rdreq_d     = (state_next == ST_POP);
        hom_req_d   = (state_next == ST_ISSUE);
        busy_d      = (state_next != ST_IDLE);
        order_err_d = order_err ||
                      ((state == ST_POP) &&
                       ((bus.fifo_q[X_MSB:X_LSB] != col) || (bus.fifo_q[Y_MSB:Y_LSB] != row)));
        proto_err_d = proto_err || (bus.hom_ready && (state != ST_WAIT));
    end

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            bus.rdreq   <= 1'b0;
            bus.hom_req <= 1'b0;
            bus.hom_x   <= '0;
            bus.hom_y   <= '0;
            busy        <= 1'b0;
            order_err   <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            bus.rdreq   <= rdreq_d;
            bus.hom_req <= hom_req_d;
            busy        <= busy_d;
            order_err   <= order_err_d;
            proto_err   <= proto_err_d;
            if (state == ST_POP) begin
                bus.hom_x <= bus.fifo_q[X_MSB:X_LSB];
                bus.hom_y <= bus.fifo_q[Y_MSB:Y_LSB];
            end
        end
    end

    pix_raster_counter #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_raster (
        .clk_25     (clk_25),
        .rst_n      (rst_n),
        .advance    (state == ST_DONE),
        .col        (col),
        .row        (row),
        .frame_done (frame_done)
    );

endmodule
